// File: rtl/pp_mm_pkg.sv
// pp_mm_pkg: shared types and sizes for the public/private multiply sequencer.
// Operand bundle carries chunk indices alongside the packed key words.
package pp_mm_pkg;

    localparam int DEPTH  = 784;
    localparam int NCHUNK = DEPTH / 4;
    localparam int A_W    = 24;
    localparam int S_W    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic [7:0]     a_idx;
        logic [7:0]     s_idx;
        logic [A_W-1:0] pk;
        logic [S_W-1:0] sk;
    } mm_operand_t;

endpackage

// File: rtl/pp_mm_operand_fifo.sv
// pp_mm_operand_fifo: small operand buffer between the key BRAMs and the multiplier.
// Head entry is presented combinationally; push and pop may coincide.
module pp_mm_operand_fifo
    import pp_mm_pkg::*;
#(
    parameter int BUF_DEPTH = 4,
    parameter int CW        = $clog2(BUF_DEPTH + 1)
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          push,
    input  logic          pop,
    input  mm_operand_t   wr_data,
    output mm_operand_t   rd_data,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    localparam int PW = $clog2(BUF_DEPTH);

    mm_operand_t   mem [BUF_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(BUF_DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Circular storage with wrap-around pointers and an occupancy count
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr <= (wr_ptr == PW'(BUF_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PW'(BUF_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pp_mm_sequencer.sv
// pp_mm_sequencer: walks every (A chunk, s chunk) pair through the chunk multiplier.
// Credit-limited BRAM reads feed a small buffer; results are counted to detect completion.
module pp_mm_sequencer
    import pp_mm_pkg::*;
#(
    parameter int DEPTH     = 784,
    parameter int RD_LAT    = 2,
    parameter int BUF_DEPTH = 4
) (
    input  logic           clk_in,
    input  logic           rst_in,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic           a_rd_en,
    output logic [7:0]     a_addr,
    input  logic [A_W-1:0] a_rd_data,
    output logic           s_rd_en,
    output logic [7:0]     s_addr,
    input  logic [S_W-1:0] s_rd_data,
    output logic           mm_A_valid,
    output logic           mm_s_valid,
    input  logic           mm_A_ready,
    input  logic           mm_s_ready,
    output logic [9:0]     mm_A_idx,
    output logic [9:0]     mm_s_idx,
    output logic [A_W-1:0] mm_pk_A,
    output logic [S_W-1:0] mm_sk_s,
    input  logic           mm_B_valid
);

    localparam int          NCH   = DEPTH / 4;
    localparam int          CW    = $clog2(BUF_DEPTH + 1);
    localparam logic [7:0]  LAST  = 8'(NCH - 1);
    localparam logic [15:0] TOTAL = 16'(NCH * NCH);

    seq_state_t        state;
    logic [15:0]       result_cnt;
    logic [RD_LAT-1:0] vpipe;
    logic [7:0]        apipe [RD_LAT];
    logic [7:0]        spipe [RD_LAT];
    logic              credit_ok;
    logic              issue;
    logic              fire;
    logic              buf_full;
    logic              buf_empty;
    logic [CW-1:0]     buf_count;
    mm_operand_t       wr_op;
    mm_operand_t       head;

    // Issue a read only while the buffer can absorb every outstanding read
    always_comb begin
        credit_ok = (int'(buf_count) + $countones(vpipe)) < BUF_DEPTH;
        issue     = (state == RUN) && credit_ok && !buf_full;
    end

    assign a_rd_en = issue;
    assign s_rd_en = issue;

    // Bundle returning BRAM data with the chunk indices it was read from
    always_comb begin
        wr_op       = '0;
        wr_op.a_idx = apipe[RD_LAT-1];
        wr_op.s_idx = spipe[RD_LAT-1];
        wr_op.pk    = a_rd_data;
        wr_op.sk    = s_rd_data;
    end

    assign fire       = !buf_empty && mm_A_ready && mm_s_ready;
    assign mm_A_valid = !buf_empty;
    assign mm_s_valid = !buf_empty;
    assign mm_A_idx   = {head.a_idx, 2'b00};
    assign mm_s_idx   = {head.s_idx, 2'b00};
    assign mm_pk_A    = head.pk;
    assign mm_sk_s    = head.sk;

    pp_mm_operand_fifo #(
        .BUF_DEPTH (BUF_DEPTH),
        .CW        (CW)
    ) u_fifo (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .push    (vpipe[RD_LAT-1]),
        .pop     (fire),
        .wr_data (wr_op),
        .rd_data (head),
        .count   (buf_count),
        .full    (buf_full),
        .empty   (buf_empty)
    );

    // Tag in-flight reads with a valid bit and their addresses
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            vpipe <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                apipe[i] <= '0;
                spipe[i] <= '0;
            end
        end else begin
            vpipe[0] <= issue;
            apipe[0] <= a_addr;
            spipe[0] <= s_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                vpipe[i] <= vpipe[i-1];
                apipe[i] <= apipe[i-1];
                spipe[i] <= spipe[i-1];
            end
        end
    end

    // Control FSM: address walk, result counting and completion
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            a_addr     <= '0;
            s_addr     <= '0;
            result_cnt <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state      <= RUN;
                        busy       <= 1'b1;
                        a_addr     <= '0;
                        s_addr     <= '0;
                        result_cnt <= '0;
                    end
                end
                RUN: begin
                    if (mm_B_valid) begin
                        result_cnt <= result_cnt + 16'd1;
                    end
                    if (issue) begin
                        if (s_addr == LAST) begin
                            s_addr <= '0;
                            if (a_addr == LAST) begin
                                a_addr <= '0;
                                state  <= DRAIN;
                            end else begin
                                a_addr <= a_addr + 8'd1;
                            end
                        end else begin
                            s_addr <= s_addr + 8'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (mm_B_valid) begin
                        result_cnt <= result_cnt + 16'd1;
                    end
                    if (buf_empty && vpipe == '0 && result_cnt == TOTAL) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pp_mm_sequencer.sv
// tb_pp_mm_sequencer: directed bench for the pair sequencer.
// Small instance (DEPTH=16) for protocol scenarios, large one (DEPTH=784) for the full sweep.
module tb_pp_mm_sequencer;
    import pp_mm_pkg::*;

    localparam int D  = 16;
    localparam int N  = D / 4;
    localparam int D2 = 784;
    localparam int N2 = D2 / 4;

    logic clk_in = 1'b0;
    logic rst_in;
    always #5 clk_in = ~clk_in;

    logic           start, busy, done, a_rd_en, s_rd_en;
    logic [7:0]     a_addr, s_addr;
    logic [A_W-1:0] a_rd_data, mm_pk_A;
    logic [S_W-1:0] s_rd_data, mm_sk_s;
    logic           mm_A_valid, mm_s_valid, mm_A_ready, mm_s_ready, mm_B_valid;
    logic [9:0]     mm_A_idx, mm_s_idx;

    logic           start_l, busy_l, done_l, a_rd_en_l, s_rd_en_l;
    logic [7:0]     a_addr_l, s_addr_l;
    logic [A_W-1:0] a_rd_data_l, mm_pk_A_l;
    logic [S_W-1:0] s_rd_data_l, mm_sk_s_l;
    logic           mm_A_valid_l, mm_s_valid_l, mm_A_ready_l, mm_s_ready_l, mm_B_valid_l;
    logic [9:0]     mm_A_idx_l, mm_s_idx_l;

    pp_mm_sequencer #(.DEPTH(D), .RD_LAT(2), .BUF_DEPTH(4)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .start(start), .busy(busy), .done(done),
        .a_rd_en(a_rd_en), .a_addr(a_addr), .a_rd_data(a_rd_data),
        .s_rd_en(s_rd_en), .s_addr(s_addr), .s_rd_data(s_rd_data),
        .mm_A_valid(mm_A_valid), .mm_s_valid(mm_s_valid),
        .mm_A_ready(mm_A_ready), .mm_s_ready(mm_s_ready),
        .mm_A_idx(mm_A_idx), .mm_s_idx(mm_s_idx),
        .mm_pk_A(mm_pk_A), .mm_sk_s(mm_sk_s), .mm_B_valid(mm_B_valid)
    );

    pp_mm_sequencer #(.DEPTH(D2), .RD_LAT(2), .BUF_DEPTH(4)) dut_l (
        .clk_in(clk_in), .rst_in(rst_in), .start(start_l), .busy(busy_l), .done(done_l),
        .a_rd_en(a_rd_en_l), .a_addr(a_addr_l), .a_rd_data(a_rd_data_l),
        .s_rd_en(s_rd_en_l), .s_addr(s_addr_l), .s_rd_data(s_rd_data_l),
        .mm_A_valid(mm_A_valid_l), .mm_s_valid(mm_s_valid_l),
        .mm_A_ready(mm_A_ready_l), .mm_s_ready(mm_s_ready_l),
        .mm_A_idx(mm_A_idx_l), .mm_s_idx(mm_s_idx_l),
        .mm_pk_A(mm_pk_A_l), .mm_sk_s(mm_sk_s_l), .mm_B_valid(mm_B_valid_l)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int exp_k, done_cnt, done_at, first_fire, last_fire, rd_cnt;
    int d0, d_tmp;
    logic           held;
    logic [47:0]    held_ops;
    logic [A_W-1:0] r1a, r2a, r1al, r2al;
    logic [S_W-1:0] r1s, r2s, r1sl, r2sl;
    int             n_l, done_cnt_l;
    logic [47:0]    last_l;

    function automatic logic [A_W-1:0] aw(input int i);
        return A_W'(32'h00A50000 + i * 7919);
    endfunction

    function automatic logic [S_W-1:0] sw(input int i);
        return S_W'(i * 3 + 1);
    endfunction

    function automatic logic [47:0] exp_ops(input int k);
        int a;
        int s;
        a = k / N;
        s = k % N;
        return {10'(4 * a), 10'(4 * s), aw(a), sw(s)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_ready(input int mode, input int c);
        unique case (mode)
            1: begin
                mm_A_ready = ((c / 3) % 2 == 0);
                mm_s_ready = (c >= 10);
            end
            3: begin
                mm_A_ready = (c >= 30);
                mm_s_ready = (c >= 30);
            end
            default: begin
                mm_A_ready = 1'b1;
                mm_s_ready = 1'b1;
            end
        endcase
    endtask

    // one cycle of the small instance: observe, then advance BRAM and multiplier models
    task automatic tick();
        logic       f;
        logic       en;
        logic [7:0] aa;
        logic [7:0] sa;
        logic [47:0] ops;
        ops = {mm_A_idx, mm_s_idx, mm_pk_A, mm_sk_s};
        f = mm_A_valid & mm_A_ready & mm_s_ready;
        check("pair_en", {s_rd_en, mm_s_valid}, {a_rd_en, mm_A_valid});
        if (held) check("stall_hold", {mm_A_valid, ops}, {1'b1, held_ops});
        held = mm_A_valid && !f;
        held_ops = ops;
        if (f) begin
            check("pair", ops, exp_ops(exp_k));
            if (exp_k == 0) first_fire = cyc;
            last_fire = cyc;
            exp_k++;
        end
        if (done) begin
            done_cnt++;
            done_at = cyc;
        end
        if (a_rd_en) rd_cnt++;
        en = a_rd_en;
        aa = a_addr;
        sa = s_addr;
        @(posedge clk_in);
        #1;
        r2a = r1a;
        r2s = r1s;
        if (en) begin
            r1a = aw(int'(aa));
            r1s = sw(int'(sa));
        end
        a_rd_data = r2a;
        s_rd_data = r2s;
        mm_B_valid = f;
        cyc++;
    endtask

    task automatic tick_l();
        logic       f;
        logic       en;
        logic [7:0] aa;
        logic [7:0] sa;
        f = mm_A_valid_l & mm_A_ready_l & mm_s_ready_l;
        if (f) begin
            n_l++;
            last_l = {mm_A_idx_l, mm_s_idx_l, mm_pk_A_l, mm_sk_s_l};
        end
        if (done_l) done_cnt_l++;
        en = a_rd_en_l;
        aa = a_addr_l;
        sa = s_addr_l;
        @(posedge clk_in);
        #1;
        r2al = r1al;
        r2sl = r1sl;
        if (en) begin
            r1al = aw(int'(aa));
            r1sl = sw(int'(sa));
        end
        a_rd_data_l = r2al;
        s_rd_data_l = r2sl;
        mm_B_valid_l = f;
        cyc++;
    endtask

    // mode 0 plain, 1 backpressure, 2 extra start, 3 credit stall, 5 stop after 7 fires
    task automatic run(input int mode, output int d_cyc);
        int c0;
        exp_k = 0;
        done_cnt = 0;
        done_at = -1;
        rd_cnt = 0;
        held = 1'b0;
        c0 = cyc;
        start = 1'b1;
        set_ready(mode, 0);
        check("idle_rd", {busy, a_rd_en}, 2'b00);
        tick();
        start = 1'b0;
        check("first_rd", {busy, a_rd_en, a_addr, s_addr}, {1'b1, 1'b1, 8'd0, 8'd0});
        for (int c = 1; c < 600 && done_cnt == 0; c++) begin
            if (mode == 5 && exp_k == 7) break;
            start = (mode == 2 && c == 5);
            set_ready(mode, c);
            if (mode == 3 && c == 30) begin
                check("credit_reads", rd_cnt, 4);
                check("credit_hold", a_rd_en, 1'b0);
            end
            tick();
        end
        start = 1'b0;
        d_cyc = done_at - c0;
        if (mode != 5) begin
            check("fires", exp_k, 16);
            for (int i = 0; i < 4; i++) tick();
            check("done_once", done_cnt, 1);
            check("idle_after", {busy, done, mm_A_valid}, 3'b000);
        end
    endtask

    initial begin
        rst_in = 1'b1;
        start = 1'b0;
        start_l = 1'b0;
        a_rd_data = '0;
        s_rd_data = '0;
        a_rd_data_l = '0;
        s_rd_data_l = '0;
        mm_A_ready = 1'b0;
        mm_s_ready = 1'b0;
        mm_A_ready_l = 1'b1;
        mm_s_ready_l = 1'b1;
        mm_B_valid = 1'b0;
        mm_B_valid_l = 1'b0;
        r1a = '0; r2a = '0; r1s = '0; r2s = '0;
        r1al = '0; r2al = '0; r1sl = '0; r2sl = '0;
        held = 1'b0;
        held_ops = '0;
        #1;
        check("reset_ctl", {busy, done, a_rd_en, s_rd_en, a_addr, s_addr}, '0);
        check("reset_mm", {mm_A_valid, mm_s_valid, mm_A_idx, mm_s_idx, mm_pk_A, mm_sk_s}, '0);
        check("reset_l", {busy_l, done_l, a_rd_en_l, mm_A_valid_l, a_addr_l}, '0);
        @(posedge clk_in);
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;

        run(0, d0);
        check("throughput", last_fire - first_fire, 15);
        check("done_lat", done_at - last_fire, 3);

        run(1, d_tmp);

        run(3, d_tmp);

        run(2, d_tmp);
        check("busy_start_timing", d_tmp, d0);

        run(5, d_tmp);
        check("pre_rst_fires", exp_k, 7);
        rst_in = 1'b1;
        #1;
        check("rst_ctl", {busy, done, a_rd_en, s_rd_en, a_addr, s_addr}, '0);
        check("rst_mm", {mm_A_valid, mm_s_valid, mm_A_idx, mm_s_idx, mm_pk_A, mm_sk_s}, '0);
        @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        mm_B_valid = 1'b0;
        r1a = '0; r2a = '0; r1s = '0; r2s = '0;
        a_rd_data = '0;
        s_rd_data = '0;
        cyc++;
        run(0, d_tmp);
        check("restart_timing", d_tmp, d0);

        n_l = 0;
        done_cnt_l = 0;
        last_l = '0;
        start_l = 1'b1;
        tick_l();
        start_l = 1'b0;
        for (int c = 1; c < 40000 && done_cnt_l == 0; c++) tick_l();
        for (int i = 0; i < 4; i++) tick_l();
        check("big_fires", n_l, N2 * N2);
        check("big_last", last_l, {10'd780, 10'd780, aw(N2 - 1), sw(N2 - 1)});
        check("big_done_once", done_cnt_l, 1);
        check("big_idle", {busy_l, mm_A_valid_l}, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
